// File: rtl/pipelined_adder_unit.sv
// pipelined_adder_unit: pipelined add/sub/accumulate unit with valid/ready
// backpressure, carry and signed-overflow flags.
module pipelined_adder_unit #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);
    logic [LATENCY-1:0] v_q, cy_q, ov_q;
    logic [WIDTH-1:0]   c_q [LATENCY];
    logic [WIDTH-1:0]   acc_q, acc_d, lhs, rhs, c_d;
    logic [WIDTH:0]     sum;
    logic               sub, clr, take, stall, cy_d, ov_d;

    always_comb begin
        sub   = op == 2'b01;
        clr   = op == 2'b11;
        stall = v_q[LATENCY-1] && !out_ready;
        take  = in_valid && !stall;
        lhs   = op[1] ? acc_q : a;
        // subtraction folds into the adder as a + ~b + 1, so one overflow rule covers all ops
        rhs   = sub ? ~b : op[1] ? a : b;
        sum   = {1'b0, lhs} + {1'b0, rhs} + {{WIDTH{1'b0}}, sub};
        c_d   = clr ? '0 : sum[WIDTH-1:0];
        cy_d  = !clr && sum[WIDTH];
        ov_d  = !clr && (lhs[WIDTH-1] == rhs[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
        acc_d = (take && op[1]) ? c_d : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cy_q  <= '0;
            ov_q  <= '0;
            acc_q <= '0;
            for (int i = 0; i < LATENCY; i++) c_q[i] <= '0;
        end else begin
            acc_q <= acc_d;
            if (!stall) begin
                v_q[0] <= take;
                if (take) begin
                    c_q[0]  <= c_d;
                    cy_q[0] <= cy_d;
                    ov_q[0] <= ov_d;
                end
                // data moves only with a valid beat so idle stages keep their last result
                for (int i = 1; i < LATENCY; i++) begin
                    v_q[i] <= v_q[i-1];
                    if (v_q[i-1]) begin
                        c_q[i]  <= c_q[i-1];
                        cy_q[i] <= cy_q[i-1];
                        ov_q[i] <= ov_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = !stall;
    assign out_valid = v_q[LATENCY-1];
    assign c         = c_q[LATENCY-1];
    assign carry     = cy_q[LATENCY-1];
    assign ovf       = ov_q[LATENCY-1];
    assign acc       = acc_q;
endmodule

// File: tb/tb_pipelined_adder_unit.sv
// tb_pipelined_adder_unit: vector table plus scoreboard bench for the pipelined adder,
// with LATENCY=1 and LATENCY=4 copies checked on the basic add stream.
module tb_pipelined_adder_unit;
    localparam int W = 32, LAT = 2, NV = 12;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, en14 = 0;
    logic [1:0] op = 0;
    logic [W-1:0] a = 0, b = 0;
    logic in_ready, out_valid, carry, ovf;
    logic [W-1:0] c, acc;
    logic iv14, r1, v1, cy1, ov1, r4, v4, cy4, ov4;
    logic [W-1:0] c1, acc1, c4, acc4;

    assign iv14 = in_valid && en14;

    pipelined_adder_unit #(.WIDTH(W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .c(c), .carry(carry), .ovf(ovf), .acc(acc));
    pipelined_adder_unit #(.WIDTH(W), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(r1), .op(op), .a(a), .b(b),
        .out_valid(v1), .out_ready(1'b1), .c(c1), .carry(cy1), .ovf(ov1), .acc(acc1));
    pipelined_adder_unit #(.WIDTH(W), .LATENCY(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv14), .in_ready(r4), .op(op), .a(a), .b(b),
        .out_valid(v4), .out_ready(1'b1), .c(c4), .carry(cy4), .ovf(ov4), .acc(acc4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [W-1:0] c; logic cy; logic ov; int en; bit lat;} exp_t;
    typedef struct {logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; logic cy; logic ov;} vec_t;
    exp_t q[$], q1[$], q4[$];
    vec_t v[NV];
    logic [W-1:0] e_c = 0;
    logic e_cy = 0, e_ov = 0;
    bit e_lat = 0;
    int pass = 0, total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) if (rst_n) begin
        exp_t e;
        if (in_valid && in_ready) q.push_back('{e_c, e_cy, e_ov, cyc + 1, e_lat});
        if (iv14 && r1) q1.push_back('{e_c, e_cy, e_ov, cyc + 1, 1'b1});
        if (iv14 && r4) q4.push_back('{e_c, e_cy, e_ov, cyc + 1, 1'b1});
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("stale_out", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("c", c, e.c);
                chk("carry", carry, e.cy);
                chk("ovf", ovf, e.ov);
                if (e.lat) chk("latency", cyc, e.en + LAT - 1);
            end
        end
        if (v1) begin
            if (q1.size() == 0) chk("stale_out_lat1", v1, 0);
            else begin
                e = q1.pop_front();
                chk("c_lat1", c1, e.c);
                chk("flags_lat1", {cy1, ov1}, {e.cy, e.ov});
                chk("latency_lat1", cyc, e.en);
            end
        end
        if (v4) begin
            if (q4.size() == 0) chk("stale_out_lat4", v4, 0);
            else begin
                e = q4.pop_front();
                chk("c_lat4", c4, e.c);
                chk("flags_lat4", {cy4, ov4}, {e.cy, e.ov});
                chk("latency_lat4", cyc, e.en + 3);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ec, input logic ecy, input logic eov, input bit l);
        int n = 0;
        in_valid = 1; op = o; a = x; b = y;
        e_c = ec; e_cy = ecy; e_ov = eov; e_lat = l;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() + q1.size() + q4.size()) != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size() + q1.size() + q4.size(), 0);
    endtask

    initial begin
        v[0]  = '{2'b00, 32'd15,        32'd20,        32'd35,        1'b0, 1'b0};
        v[1]  = '{2'b00, 32'd34,        32'd45,        32'd79,        1'b0, 1'b0};
        v[2]  = '{2'b00, 32'hFFFFFFFF,  32'd1,         32'h0,         1'b1, 1'b0};
        v[3]  = '{2'b00, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0, 1'b1};
        v[4]  = '{2'b00, 32'h80000000,  32'h80000000,  32'h0,         1'b1, 1'b1};
        v[5]  = '{2'b01, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0, 1'b0};
        v[6]  = '{2'b01, 32'd7,         32'd5,         32'd2,         1'b1, 1'b0};
        v[7]  = '{2'b01, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1, 1'b1};
        v[8]  = '{2'b11, 32'h1234,      32'd9,         32'h0,         1'b0, 1'b0};
        v[9]  = '{2'b10, 32'd10,        32'hDEAD,      32'd10,        1'b0, 1'b0};
        v[10] = '{2'b10, 32'hFFFFFFF8,  32'hDEAD,      32'd2,         1'b1, 1'b0};
        v[11] = '{2'b10, 32'd3,         32'hDEAD,      32'd5,         1'b0, 1'b0};

        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_c", c, 0);
        chk("rst_flags", {carry, ovf}, 0);
        chk("rst_acc", acc, 0);
        @(posedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < NV; i++) begin
            en14 = (i < 2);
            send(v[i].op, v[i].a, v[i].b, v[i].c, v[i].cy, v[i].ov, 1'b1);
        end
        en14 = 0;
        drain();
        chk("acc_chain", acc, 5);
        chk("acc_lat1_untouched", acc1, 0);
        chk("acc_lat4_untouched", acc4, 0);

        out_ready = 0;
        fork
            begin
                for (int k = 1; k <= 4; k++) send(2'b00, k, k, 2 * k, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                for (int k = 0; k < 5; k++) begin
                    chk("bp_out_valid", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_c_hold", c, 2);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1;
            end
        join
        drain();

        send(2'b11, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        send(2'b10, 7, 0, 7, 1'b0, 1'b0, 1'b1);
        send(2'b10, 9, 0, 16, 1'b0, 1'b0, 1'b1);
        chk("pre_rst_acc", acc, 16);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_c", c, 0);
        chk("mid_rst_acc", acc, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete();
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        repeat (4) begin
            chk("post_rst_idle", out_valid, 0);
            @(posedge clk);
            #1;
        end
        send(2'b00, 1, 2, 3, 1'b0, 1'b0, 1'b1);
        drain();

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
